// File: rtl/fpga_cfg_pkg.sv
// ============================================================================
//  Module      : fpga_cfg_pkg
//  Description : Fixed-point format constants and the shared saturation helper
//                used by the streaming reducers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpga_cfg_pkg;

    localparam int FP_WIDTH     = 32;
    localparam int FP_QINT      = 15;
    localparam int FP_QFRAC     = 16;
    localparam int FP_MAX_GROUP = 256;
    localparam int FP_ACC_GUARD = 8;

    // Widest accumulator the saturation helper can take.
    localparam int FX_SAT_W = 64;

    typedef struct packed {
        logic                clip;
        logic [FX_SAT_W-1:0] value;
    } fx_sat_t;

    // Clip a signed accumulator to a signed 'width'-bit range.
    function automatic fx_sat_t fx_sat(input logic signed [FX_SAT_W-1:0] acc,
                                       input int width);
        logic signed [FX_SAT_W-1:0] hi;
        logic signed [FX_SAT_W-1:0] lo;
        fx_sat_t                    r;
        hi = $signed((FX_SAT_W'(1) << (width - 1)) - FX_SAT_W'(1));
        lo = ~hi;
        if (acc > hi) begin
            r = '{clip: 1'b1, value: hi};
        end else if (acc < lo) begin
            r = '{clip: 1'b1, value: lo};
        end else begin
            r = '{clip: 1'b0, value: acc};
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fx_group_accum.sv
// ============================================================================
//  Module      : fx_group_accum
//  Description : Streaming signed fixed-point group accumulator with a
//                saturated, registered valid/ready result per group.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fx_group_accum
    import fpga_cfg_pkg::*;
#(
    parameter int WIDTH   = FP_WIDTH,
    parameter int QINT    = FP_QINT,
    parameter int QFRAC   = FP_QFRAC,
    parameter int MAX_LEN = FP_MAX_GROUP,
    parameter int GUARD   = FP_ACC_GUARD,
    parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [WIDTH-1:0] data_in,
    input  logic             last_in,
    input  logic [CNT_W-1:0] group_len,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [WIDTH-1:0] sum_out,
    output logic [CNT_W-1:0] cnt_out,
    output logic             sat_out
);

    localparam int ACC_W = WIDTH + GUARD;

    generate
        if (GUARD < $clog2(MAX_LEN)) begin : g_guard_chk
            $error("fx_group_accum: GUARD too small for MAX_LEN");
        end
        if (ACC_W >= FX_SAT_W) begin : g_accw_chk
            $error("fx_group_accum: accumulator wider than fx_sat supports");
        end
        if (QINT + QFRAC + 1 != WIDTH) begin : g_fmt_chk
            $error("fx_group_accum: QINT+QFRAC+1 must equal WIDTH");
        end
    endgenerate

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        beats_q, beats_d;
    logic [CNT_W-1:0]        len_q, len_d;
    logic                    in_group_q, in_group_d;
    logic                    valid_q, valid_d;
    logic [WIDTH-1:0]        sum_q, sum_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    sat_q, sat_d;

    logic                    w_accept;
    logic                    w_final;
    logic signed [ACC_W-1:0] w_sext;
    logic signed [ACC_W-1:0] w_acc_next;
    logic [CNT_W-1:0]        w_beats_next;
    logic [CNT_W-1:0]        w_len_eff;
    fx_sat_t                 w_sat;
    logic [FX_SAT_W-WIDTH-1:0] w_sat_hi_unused;

    assign ready_out = !valid_q || ready_in;
    assign w_accept  = valid_in && ready_out;

    assign w_sext       = {{GUARD{data_in[WIDTH-1]}}, data_in};
    assign w_acc_next   = in_group_q ? (acc_q + w_sext) : w_sext;
    assign w_beats_next = in_group_q ? (beats_q + CNT_W'(1)) : CNT_W'(1);
    // The length is latched on the first beat; a zero length means a 1-beat group.
    assign w_len_eff    = in_group_q ? len_q
                        : ((group_len == '0) ? CNT_W'(1) : group_len);
    assign w_final      = (w_beats_next == w_len_eff) || last_in;

    assign w_sat           = fx_sat({{(FX_SAT_W-ACC_W){w_acc_next[ACC_W-1]}}, w_acc_next},
                                    WIDTH);
    assign w_sat_hi_unused = w_sat.value[FX_SAT_W-1:WIDTH];

    always_comb begin
        acc_d      = acc_q;
        beats_d    = beats_q;
        len_d      = len_q;
        in_group_d = in_group_q;
        valid_d    = valid_q;
        sum_d      = sum_q;
        cnt_d      = cnt_q;
        sat_d      = sat_q;

        if (valid_q && ready_in) begin
            valid_d = 1'b0;
        end

        if (w_accept) begin
            acc_d      = w_acc_next;
            beats_d    = w_beats_next;
            len_d      = w_len_eff;
            in_group_d = !w_final;
            // Loading here also covers drain-and-reload with no bubble.
            if (w_final) begin
                valid_d = 1'b1;
                sum_d   = w_sat.value[WIDTH-1:0];
                cnt_d   = w_beats_next;
                sat_d   = w_sat.clip;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q      <= '0;
            beats_q    <= '0;
            len_q      <= '0;
            in_group_q <= 1'b0;
            valid_q    <= 1'b0;
            sum_q      <= '0;
            cnt_q      <= '0;
            sat_q      <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            beats_q    <= beats_d;
            len_q      <= len_d;
            in_group_q <= in_group_d;
            valid_q    <= valid_d;
            sum_q      <= sum_d;
            cnt_q      <= cnt_d;
            sat_q      <= sat_d;
        end
    end

    assign valid_out = valid_q;
    assign sum_out   = sum_q;
    assign cnt_out   = cnt_q;
    assign sat_out   = sat_q;

    a_hold_stable: assert property (
        @(posedge clk) disable iff (rst)
        (valid_q && !ready_in) |=> ($stable({sum_q, cnt_q, sat_q}) && valid_q)
    );

endmodule

`default_nettype wire

// File: tb/tb_fx_group_accum.sv
// ============================================================================
//  Module      : tb_fx_group_accum
//  Description : Directed self-checking bench for fx_group_accum with a
//                group-level reference model and per-cycle output compare.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fx_group_accum;

    localparam int WIDTH = 32;
    localparam int CNT_W = 9;

    logic             clk = 1'b0;
    logic             rst;
    logic             valid_in;
    logic             ready_out;
    logic [WIDTH-1:0] data_in;
    logic             last_in;
    logic [CNT_W-1:0] group_len;
    logic             valid_out;
    logic             ready_in;
    logic [WIDTH-1:0] sum_out;
    logic [CNT_W-1:0] cnt_out;
    logic             sat_out;

    int n_total = 0;
    int n_bad   = 0;

    fx_group_accum u_dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_in   (data_in),
        .last_in   (last_in),
        .group_len (group_len),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .sum_out   (sum_out),
        .cnt_out   (cnt_out),
        .sat_out   (sat_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: one entry per finished group, head = result on display.
    typedef struct {
        logic [31:0] sum;
        int          cnt;
        bit          sat;
    } exp_t;

    exp_t   q[$];
    longint m_acc;
    int     m_cnt;
    int     m_len;
    bit     m_in;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_acc = 0;
            m_cnt = 0;
            m_in  = 0;
        end else begin
            if (valid_out && ready_in) begin
                chk("result_expected", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) void'(q.pop_front());
            end
            if (valid_in && ready_out) begin
                if (!m_in) begin
                    m_acc = longint'($signed(data_in));
                    m_cnt = 1;
                    m_len = (group_len == 0) ? 1 : int'(group_len);
                    m_in  = 1;
                end else begin
                    m_acc = m_acc + longint'($signed(data_in));
                    m_cnt = m_cnt + 1;
                end
                if (m_cnt == m_len || last_in) begin
                    exp_t e;
                    if (m_acc > 64'sd2147483647) begin
                        e.sum = 32'h7FFF_FFFF; e.sat = 1;
                    end else if (m_acc < -64'sd2147483648) begin
                        e.sum = 32'h8000_0000; e.sat = 1;
                    end else begin
                        e.sum = m_acc[31:0]; e.sat = 0;
                    end
                    e.cnt = m_cnt;
                    q.push_back(e);
                    m_in = 0;
                end
            end
        end
    end

    always begin
        @(negedge clk);
        #2;
        chk("valid_out", 64'(valid_out), 64'(q.size() != 0));
        chk("ready_out", 64'(ready_out), 64'((q.size() == 0) || ready_in));
        if (q.size() != 0 && valid_out) begin
            chk("sum_out", 64'(sum_out), 64'(q[0].sum));
            chk("cnt_out", 64'(cnt_out), 64'(q[0].cnt));
            chk("sat_out", 64'(sat_out), 64'(q[0].sat));
        end
    end

    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic beat(input logic [31:0] d, input logic l, input logic [CNT_W-1:0] gl);
        int n;
        valid_in  = 1'b1;
        data_in   = d;
        last_in   = l;
        group_len = gl;
        n = 0;
        #1;
        while (!ready_out && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!ready_out) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic lit(input string name, input logic [31:0] s, input int c, input bit sa);
        chk({name, "_valid"}, 64'(valid_out), 64'd1);
        chk({name, "_sum"},   64'(sum_out),   64'(s));
        chk({name, "_cnt"},   64'(cnt_out),   64'(c));
        chk({name, "_sat"},   64'(sat_out),   64'(sa));
    endtask

    initial begin
        rst       = 1'b1;
        valid_in  = 1'b0;
        data_in   = '0;
        last_in   = 1'b0;
        group_len = '0;
        ready_in  = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(valid_out), 64'd0);
        chk("rst_sum",   64'(sum_out),   64'd0);
        chk("rst_cnt",   64'(cnt_out),   64'd0);
        chk("rst_sat",   64'(sat_out),   64'd0);
        rst = 1'b0;
        #1;
        chk("rst_ready", 64'(ready_out), 64'd1);
        @(negedge clk);

        // Basic sum: 1.0 + 2.0 - 0.5 + 0.25 = 2.75
        beat(32'h0001_0000, 1'b0, 9'd4);
        beat(32'h0002_0000, 1'b0, 9'd4);
        beat(32'hFFFF_8000, 1'b0, 9'd4);
        beat(32'h0000_4000, 1'b0, 9'd4);
        lit("basic", 32'h0002_C000, 4, 1'b0);
        @(negedge clk);

        // Back-pressure: hold 4.0 for 5 cycles, then release mid-stall.
        ready_in = 1'b0;
        for (int i = 0; i < 4; i++) beat(32'h0001_0000, 1'b0, 9'd4);
        for (int i = 0; i < 5; i++) begin
            lit("hold", 32'h0004_0000, 4, 1'b0);
            chk("hold_ready", 64'(ready_out), 64'd0);
            @(negedge clk);
        end
        fork
            begin
                repeat (2) @(negedge clk);
                ready_in = 1'b1;
            end
        join_none
        beat(32'h0002_0000, 1'b0, 9'd2);
        beat(32'h0003_0000, 1'b0, 9'd2);
        lit("after_bp", 32'h0005_0000, 2, 1'b0);

        // Saturation both ways.
        beat(32'h7FFF_0000, 1'b0, 9'd2);
        beat(32'h7FFF_0000, 1'b0, 9'd2);
        lit("sat_pos", 32'h7FFF_FFFF, 2, 1'b1);
        beat(32'h8000_0000, 1'b0, 9'd2);
        beat(32'h8000_0000, 1'b0, 9'd2);
        lit("sat_neg", 32'h8000_0000, 2, 1'b1);

        // Early end, then a fresh group (mid-group length change ignored).
        beat(32'h0001_0000, 1'b0, 9'd8);
        beat(32'h0001_0000, 1'b0, 9'd1);
        beat(32'h0001_0000, 1'b1, 9'd8);
        lit("early", 32'h0003_0000, 3, 1'b0);
        beat(32'h0001_0000, 1'b0, 9'd2);
        beat(32'h0001_0000, 1'b0, 9'd2);
        lit("fresh", 32'h0002_0000, 2, 1'b0);
        @(negedge clk);

        // Reset mid-group discards the partial sum.
        beat(32'h0001_0000, 1'b0, 9'd4);
        beat(32'h0001_0000, 1'b0, 9'd4);
        rst = 1'b1;
        #2;
        chk("midrst_valid", 64'(valid_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        beat(32'h0000_8000, 1'b1, 9'd4);
        lit("post_rst", 32'h0000_8000, 1, 1'b0);
        @(negedge clk);

        // Full-rate single-beat groups, alternating group_len 1 and 0.
        for (int i = 1; i <= 4; i++) begin
            beat(32'(i) << 16, 1'b0, (i % 2 == 1) ? 9'd1 : 9'd0);
            lit("len1", 32'(i) << 16, 1, 1'b0);
            chk("len1_ready", 64'(ready_out), 64'd1);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
